polyphase_coeff_loader: RTL
===========================

POLYPHASE_COEFF_LOADER -- requirements
Module: polyphase_coeff_loader

Interface
REQ-001 Parameter NUMBER_TAPS, default 32, total prototype-filter taps; SHALL be a multiple of RATE_CHANGE.
REQ-002 Parameter RATE_CHANGE, default 8, number of polyphase sections; SHALL be a power of two.
REQ-003 Parameter DATA_IN_WIDTH, default 16, sample width.
REQ-004 Parameter COEFFICIENT_WIDTH, default 16, coefficient width.
REQ-005 aclk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 s_coeff_tdata / s_coeff_tvalid / s_coeff_tready / s_coeff_tlast  in/in/out/in  COEFFICIENT_WIDTH/1/1/1  coefficient reload stream, one packet per reload.
REQ-008 s_data_tdata / s_data_tvalid / s_data_tready / s_data_tlast  in/in/out/in  DATA_IN_WIDTH/1/1/1  upstream sample stream.
REQ-009 m_data_tdata / m_data_tvalid / m_data_tready / m_data_tlast  out/out/in/out  DATA_IN_WIDTH/1/1/1  gated sample stream to the filter.
REQ-010 filt_out_tvalid / filt_out_tready / filt_out_tlast  in/in/in  1/1/1  monitor taps on the filter output handshake.
REQ-011 coeffs_wren / coeffs_addr / coeffs_wdata  out/out/out  1/clog2(NUMBER_TAPS)/COEFFICIENT_WIDTH  filter coefficient write port.
REQ-012 busy / load_done / load_error  out/out/out  1/1/1  status: reload in progress, one-cycle completion pulse, sticky error.

Function
REQ-013 FSM states RUN, DRAIN, LOAD, FLUSH; reset state RUN.
REQ-014 RUN: m_data_* SHALL equal s_data_* combinationally, s_data_tready = m_data_tready; s_coeff_tready = 0.
REQ-015 in_frame flag: set on accepted non-last sample, cleared on accepted last sample; same-cycle set/clear resolves to the accepted beat's tlast.
REQ-016 pending flag: set on any accepted m_data sample, cleared on filt_out_tvalid & filt_out_tready & filt_out_tlast; simultaneous set and clear SHALL leave pending = 1.
REQ-017 RUN -> DRAIN when s_coeff_tvalid = 1; busy asserts the following cycle.
REQ-018 DRAIN: input gated only after in_frame = 0 (current frame completes; no new frame starts); s_data_tready = 0 and m_data_tvalid = 0 once gated.
REQ-019 DRAIN -> LOAD when in_frame = 0 and pending = 0; if both already 0 on RUN exit, DRAIN lasts exactly one cycle.
REQ-020 LOAD: s_coeff_tready = 1; beat k accepted SHALL produce coeffs_wren = 1, coeffs_addr = k, coeffs_wdata = beat data exactly one cycle later (registered); k starts at 0.
REQ-021 Beat NUMBER_TAPS-1 with tlast = 1: LOAD -> RUN, load_done pulses one cycle after the last write cycle, load_error cleared.
REQ-022 tlast before beat NUMBER_TAPS-1 (short packet): beat written, LOAD -> RUN, load_error = 1, load_done pulses.
REQ-023 Beat NUMBER_TAPS-1 without tlast (long packet): LOAD -> FLUSH; FLUSH keeps s_coeff_tready = 1, coeffs_wren = 0, discards beats until tlast, then -> RUN with load_error = 1 and load_done pulse.
REQ-024 Address counter SHALL NOT wrap; no write beyond NUMBER_TAPS-1.
REQ-025 Sample path gated (s_data_tready = 0, m_data_tvalid = 0) in LOAD and FLUSH; busy = 1 in DRAIN, LOAD, FLUSH.
REQ-026 coeffs_addr SHALL be the linear prototype index (low clog2(RATE_CHANGE) bits select phase section, upper bits select tap).

Reset
REQ-027 reset SHALL force RUN, in_frame = 0, pending = 0, counter = 0, coeffs_wren = 0, coeffs_addr = 0, coeffs_wdata = 0, busy = 0, load_done = 0, load_error = 0.
REQ-028 reset mid-LOAD SHALL abandon the reload without further writes; a partially written coefficient set is not recovered.

Structure
REQ-029 Shared package: state enum, COEFF_ADDR_WIDTH = clog2(NUMBER_TAPS), PHASE_WIDTH = clog2(RATE_CHANGE).
REQ-030 One sub-module natural: stream_frame_tracker (in_frame/pending flags), instanced once.

Verification
REQ-031 Idle, 32-beat packet 0..31, tlast on beat 31 -> 32 writes addr 0..31 data 0..31, load_done once, load_error 0.
REQ-032 Coeff valid mid 100-sample frame -> frame completes; new samples blocked; first write only after filt_out tlast handshake.
REQ-033 10-beat packet, tlast on beat 9 -> 10 writes addr 0..9, load_error 1, RUN resumes.
REQ-034 40-beat packet -> 32 writes, 8 beats discarded, load_error 1, load_done after beat 39.
REQ-035 reset asserted after write 12 -> no further writes, all outputs at reset values next cycle, samples pass next cycle.
REQ-036 s_coeff_tvalid toggled 1-0 in LOAD -> writes only on accepted beats, addresses contiguous.

Source files
------------

// File: rtl/polyphase_coeff_loader_pkg.sv
// rtl/polyphase_coeff_loader_pkg.sv - shared constants and FSM encoding for the coefficient loader
package polyphase_coeff_loader_pkg;

    localparam int DEFAULT_NUMBER_TAPS = 32;
    localparam int DEFAULT_RATE_CHANGE = 8;
    localparam int COEFF_ADDR_WIDTH    = $clog2(DEFAULT_NUMBER_TAPS);
    localparam int PHASE_WIDTH         = $clog2(DEFAULT_RATE_CHANGE);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    function automatic logic is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/polyphase_coeff_loader_if.sv
// rtl/polyphase_coeff_loader_if.sv - coefficient, sample and filter-monitor stream bundle
interface polyphase_coeff_loader_if #(
    parameter int DATA_IN_WIDTH     = 16,
    parameter int COEFFICIENT_WIDTH = 16
);
    logic [COEFFICIENT_WIDTH-1:0] s_coeff_tdata;
    logic                         s_coeff_tvalid;
    logic                         s_coeff_tready;
    logic                         s_coeff_tlast;

    logic [DATA_IN_WIDTH-1:0]     s_data_tdata;
    logic                         s_data_tvalid;
    logic                         s_data_tready;
    logic                         s_data_tlast;

    logic [DATA_IN_WIDTH-1:0]     m_data_tdata;
    logic                         m_data_tvalid;
    logic                         m_data_tready;
    logic                         m_data_tlast;

    logic                         filt_out_tvalid;
    logic                         filt_out_tready;
    logic                         filt_out_tlast;

    modport slave (
        input  s_coeff_tdata, s_coeff_tvalid, s_coeff_tlast,
        output s_coeff_tready,
        input  s_data_tdata, s_data_tvalid, s_data_tlast,
        output s_data_tready,
        output m_data_tdata, m_data_tvalid, m_data_tlast,
        input  m_data_tready,
        input  filt_out_tvalid, filt_out_tready, filt_out_tlast
    );

    modport master (
        output s_coeff_tdata, s_coeff_tvalid, s_coeff_tlast,
        input  s_coeff_tready,
        output s_data_tdata, s_data_tvalid, s_data_tlast,
        input  s_data_tready,
        input  m_data_tdata, m_data_tvalid, m_data_tlast,
        output m_data_tready,
        output filt_out_tvalid, filt_out_tready, filt_out_tlast
    );

endinterface

// File: rtl/polyphase_coeff_loader_stream_frame_tracker.sv
// rtl/polyphase_coeff_loader_stream_frame_tracker.sv - tracks open input frame and samples still inside the filter
module stream_frame_tracker (
    input  logic aclk,
    input  logic reset,
    input  logic beat_accepted,
    input  logic beat_last,
    input  logic filt_done,
    output logic in_frame,
    output logic pending
);

    always_ff @(posedge aclk) begin
        if (reset) begin
            in_frame <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (beat_accepted) begin
                in_frame <= !beat_last;
            end
            // A new sample entering the filter outranks a frame leaving it.
            if (beat_accepted) begin
                pending <= 1'b1;
            end else if (filt_done) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/polyphase_coeff_loader.sv
// rtl/polyphase_coeff_loader.sv - quiesces the sample path and streams a new prototype coefficient set into the filter
module polyphase_coeff_loader
    import polyphase_coeff_loader_pkg::*;
#(
    parameter int NUMBER_TAPS       = DEFAULT_NUMBER_TAPS,
    parameter int RATE_CHANGE       = DEFAULT_RATE_CHANGE,
    parameter int DATA_IN_WIDTH     = 16,
    parameter int COEFFICIENT_WIDTH = 16
) (
    input  logic                           aclk,
    input  logic                           reset,
    polyphase_coeff_loader_if.slave        bus,
    output logic                           coeffs_wren,
    output logic [$clog2(NUMBER_TAPS)-1:0] coeffs_addr,
    output logic [COEFFICIENT_WIDTH-1:0]   coeffs_wdata,
    output logic                           busy,
    output logic                           load_done,
    output logic                           load_error
);

    localparam int             AW        = $clog2(NUMBER_TAPS);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(NUMBER_TAPS - 1);

    if (!is_pow2(RATE_CHANGE) || (NUMBER_TAPS % RATE_CHANGE) != 0) begin : g_bad_params
        $error("NUMBER_TAPS must be a multiple of a power-of-two RATE_CHANGE");
    end

    logic [1:0]               state;
    logic [1:0]               state_next;
    logic [AW-1:0]            cnt;
    logic                     in_frame;
    logic                     pending;
    logic                     pass;
    logic                     coeff_accept;
    logic                     load_beat;
    logic                     sample_accept;
    logic                     filt_done;
    logic                     at_last;
    logic                     finish_now;
    logic                     finish_err;
    logic                     finish_q;
    logic                     finish_err_q;
    logic [DATA_IN_WIDTH-1:0] sample_data;

    // In DRAIN the open frame may still complete, but no new frame is let in.
    assign pass          = (state == ST_RUN) || ((state == ST_DRAIN) && in_frame);
    assign sample_data   = bus.s_data_tdata;
    assign bus.m_data_tdata  = sample_data;
    assign bus.m_data_tlast  = bus.s_data_tlast;
    assign bus.m_data_tvalid = bus.s_data_tvalid & pass;
    assign bus.s_data_tready = bus.m_data_tready & pass;
    assign bus.s_coeff_tready = (state == ST_LOAD) || (state == ST_FLUSH);

    assign coeff_accept  = bus.s_coeff_tvalid & bus.s_coeff_tready;
    assign load_beat     = coeff_accept && (state == ST_LOAD);
    assign sample_accept = bus.m_data_tvalid & bus.m_data_tready;
    assign filt_done     = bus.filt_out_tvalid & bus.filt_out_tready & bus.filt_out_tlast;
    assign at_last       = (cnt == LAST_ADDR);
    assign busy          = (state != ST_RUN);

    stream_frame_tracker u_tracker (
        .aclk          (aclk),
        .reset         (reset),
        .beat_accepted (sample_accept),
        .beat_last     (bus.s_data_tlast),
        .filt_done     (filt_done),
        .in_frame      (in_frame),
        .pending       (pending)
    );

    always_comb begin
        state_next = state;
        finish_now = 1'b0;
        finish_err = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.s_coeff_tvalid) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!in_frame && !pending) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (coeff_accept) begin
                    if (bus.s_coeff_tlast) begin
                        state_next = ST_RUN;
                        finish_now = 1'b1;
                        finish_err = !at_last;
                    end else if (at_last) begin
                        state_next = ST_FLUSH;
                    end
                end
            end
            default: begin
                if (coeff_accept && bus.s_coeff_tlast) begin
                    state_next = ST_RUN;
                    finish_now = 1'b1;
                    finish_err = 1'b1;
                end
            end
        endcase
    end

    // coeffs_addr is the linear prototype index: low PHASE bits pick the section.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state        <= ST_RUN;
            cnt          <= '0;
            coeffs_wren  <= 1'b0;
            coeffs_addr  <= '0;
            coeffs_wdata <= '0;
            finish_q     <= 1'b0;
            finish_err_q <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            state       <= state_next;
            coeffs_wren <= load_beat;
            if (load_beat) begin
                coeffs_addr  <= cnt;
                coeffs_wdata <= bus.s_coeff_tdata;
            end
            if (state != ST_LOAD) begin
                cnt <= '0;
            end else if (load_beat && !at_last) begin
                cnt <= cnt + AW'(1);
            end
            finish_q     <= finish_now;
            finish_err_q <= finish_err;
            load_done    <= finish_q;
            if (finish_q) load_error <= finish_err_q;
        end
    end

endmodule
